// File: rtl/reflet_ram_reader_if.sv
// reflet_ram_reader_if: start/config, RAM read port and output stream of the block reader
interface reflet_ram_reader_if #(parameter int addrSize = 7, parameter int depth = 8);
  logic start;
  logic [addrSize-1:0] base_addr;
  logic [addrSize:0] length;
  logic ram_enable;
  logic [addrSize-1:0] ram_addr_read;
  logic [depth-1:0] ram_data;
  logic [depth-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic done;
  modport master (
    input start, base_addr, length, ram_data, out_ready,
    output ram_enable, ram_addr_read, out_data, out_valid, busy, done
  );
  modport slave (
    output start, base_addr, length, ram_data, out_ready,
    input ram_enable, ram_addr_read, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/reflet_ram_reader.sv
// reflet_ram_reader: walks a RAM address block and streams the words over valid/ready
module reflet_ram_reader #(
  parameter int addrSize = 7,
  parameter int size = 128,
  parameter int depth = 8
) (
  input logic clk,
  input logic reset,
  reflet_ram_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  localparam logic [addrSize:0] ONE = 1;
  localparam logic [addrSize-1:0] LAST_ADDR = addrSize'(size - 1);
  state_t state, state_n;
  logic [addrSize-1:0] addr;
  logic [addrSize:0] remaining;
  logic inflight;
  logic [depth-1:0] mem [2];
  logic head;
  logic [1:0] count;
  logic [2:0] occ;
  logic pop, accept, issue, last_issue, last_pop;
  assign pop = bus.out_valid && bus.out_ready;
  assign accept = state == IDLE && bus.start;
  // occupancy after this cycle's push/pop; a new issue lands one cycle later
  assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = state == RUN && occ < 3'd2;
  assign last_issue = issue && remaining == ONE;
  assign last_pop = state == DRAIN && pop && count == 2'd1 && !inflight;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.start ? (bus.length == '0 ? FINISH : RUN) : IDLE) :
              state == RUN ? (last_issue ? DRAIN : RUN) :
              state == DRAIN ? (last_pop ? FINISH : DRAIN) : IDLE;
  end
  assign bus.busy = state == RUN || state == DRAIN;
  assign bus.ram_enable = bus.busy;
  assign bus.done = state == FINISH;
  assign bus.ram_addr_read = addr;
  assign bus.out_valid = count != 2'd0;
  assign bus.out_data = mem[head];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      inflight <= 1'b0;
      head <= 1'b0;
      count <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr <= bus.base_addr;
        remaining <= bus.length;
      end else if (issue) begin
        remaining <= remaining - ONE;
        if (!last_issue) addr <= addr == LAST_ADDR ? '0 : addr + 1'b1;
      end
      inflight <= issue;
      if (inflight) mem[head ^ count[0]] <= bus.ram_data;
      if (pop) head <= ~head;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_reflet_ram_reader.sv
// tb_reflet_ram_reader: directed per-cycle table plus transfer table against a RAM model
module tb_reflet_ram_reader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  reflet_ram_reader_if bus ();
  reflet_ram_reader dut (.clk(clk), .reset(reset), .bus(bus));
  logic [7:0] ram [128];
  logic [7:0] rq = 8'h00;
  always @(posedge clk) if (bus.ram_enable) rq <= ram[bus.ram_addr_read];
  assign bus.ram_data = rq;
  int checks = 0;
  int errors = 0;
  typedef struct { logic v; logic [7:0] d; logic b, dn, en; logic [6:0] a; } cyc_t;
  typedef struct { logic [6:0] b; logic [7:0] len; logic [15:0] pat; int inj; } xfer_t;
  cyc_t t1 [8] = '{
    '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 7'd5},
    '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 7'd6},
    '{1'b1, 8'hA0, 1'b1, 1'b0, 1'b1, 7'd7},
    '{1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 7'd8},
    '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 7'd8},
    '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 7'd8},
    '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd8},
    '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd8}
  };
  xfer_t xt [5] = '{
    '{7'd126, 8'd4, 16'hFFFF, 0},
    '{7'd60, 8'd8, 16'h9999, 0},
    '{7'd10, 8'd6, 16'hFFFF, 3},
    '{7'd50, 8'd3, 16'hFFFF, 0},
    '{7'd77, 8'd128, 16'hB6D5, 0}
  };
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] f(input int a);
    return 8'h9B + a[7:0];
  endfunction
  task automatic run_xfer(input logic [6:0] b, input logic [7:0] len, input logic [15:0] pat, input int inj);
    int cyc, k, n_addr;
    logic [6:0] a_prev;
    logic prev_stall;
    logic [7:0] prev_data;
    logic seen_done;
    cyc = 0; k = 0; n_addr = 0; a_prev = b; prev_stall = 0; prev_data = 0; seen_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = b; bus.length = len; bus.out_ready = pat[0];
    while (!seen_done) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (cyc == inj) begin
        bus.start = 1'b1; bus.base_addr = b + 7'd40; bus.length = 8'd3;
      end
      bus.out_ready = pat[cyc % 16];
      #1;
      if (cyc == 1) begin
        chk("addr_first", bus.ram_addr_read, b);
        n_addr = 1;
      end else if (bus.busy && bus.ram_addr_read != a_prev) begin
        chk("addr_seq", bus.ram_addr_read, (a_prev == 7'd127) ? 7'd0 : a_prev + 7'd1);
        n_addr++;
      end
      a_prev = bus.ram_addr_read;
      chk("enable", bus.ram_enable, bus.busy);
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("data", bus.out_data, f((b + k) % 128));
        k++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      seen_done = bus.done;
      if (!seen_done && cyc > 700) begin
        errors++;
        $display("FAIL timeout: no done after %0d cycles, expected done", cyc);
        seen_done = 1'b1;
      end
    end
    chk("word_count", k, len);
    chk("addr_count", n_addr, len);
    @(negedge clk);
    #1;
    chk("done_pulse", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
  endtask
  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 8'h9B + i[7:0];
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_enable", bus.ram_enable, 0);
    chk("rst_addr", bus.ram_addr_read, 0);
    reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 7'd5; bus.length = 8'd4;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      chk("t1_valid", bus.out_valid, t1[i].v);
      if (t1[i].v) chk("t1_data", bus.out_data, t1[i].d);
      chk("t1_busy", bus.busy, t1[i].b);
      chk("t1_done", bus.done, t1[i].dn);
      chk("t1_enable", bus.ram_enable, t1[i].en);
      chk("t1_addr", bus.ram_addr_read, t1[i].a);
    end
    for (int i = 0; i < 5; i++) run_xfer(xt[i].b, xt[i].len, xt[i].pat, xt[i].inj);
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 7'd3; bus.length = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("len0_done", bus.done, 1);
    chk("len0_busy", bus.busy, 0);
    chk("len0_enable", bus.ram_enable, 0);
    chk("len0_valid", bus.out_valid, 0);
    @(negedge clk);
    #1;
    chk("len0_done_end", bus.done, 0);
    chk("len0_enable_end", bus.ram_enable, 0);
    chk("len0_valid_end", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 7'd20; bus.length = 8'd8;
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    chk("pre_rst_valid", bus.out_valid, 1);
    chk("pre_rst_data", bus.out_data, f(20));
    #1 reset = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_data", bus.out_data, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_enable", bus.ram_enable, 0);
    chk("arst_addr", bus.ram_addr_read, 0);
    chk("arst_done", bus.done, 0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("arst_no_done", bus.done, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    run_xfer(7'd40, 8'd5, 16'hFFFF, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
